// File: rtl/seg7_pkg.sv
// Shared definitions for seven-segment encode/decode blocks.
//   SEG7_HEX   : active-high {g..a} pattern for each hex digit 0..F
//   SEG7_BLANK : all segments off
//   state_e    : settle tracker states of the scan decoder
package seg7_pkg;
  localparam int DIGITS = 4;
  localparam int SEG_W  = 7;

  localparam logic [SEG_W-1:0]  SEG7_BLANK = 7'h00;
  localparam logic [DIGITS-1:0] SEL_IDLE   = '1;

  // Packed concatenation: leftmost entry is index 15 ("F").
  localparam logic [15:0][SEG_W-1:0] SEG7_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {SETTLE, HELD} state_e;
endpackage

// File: rtl/seg_scan_decoder_if.sv
// Scan-line / decoded-frame bundle for seg_scan_decoder.
//   digit_select, seg : scanned board lines (active-low), driven by master
//   digits, blank_mask, frame_valid, decode_error : decoded results from slave
interface seg_scan_decoder_if;
  import seg7_pkg::*;
  logic [DIGITS-1:0]   digit_select;
  logic [SEG_W-1:0]    seg;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   blank_mask;
  logic                frame_valid;
  logic                decode_error;

  modport master (output digit_select, seg,
                  input  digits, blank_mask, frame_valid, decode_error);
  modport slave  (input  digit_select, seg,
                  output digits, blank_mask, frame_valid, decode_error);
endinterface

// File: rtl/seg7_to_hex.sv
// Combinational seven-segment pattern to hex decoder.
//   pattern  : active-high {g..a}
//   nibble   : decoded value (0 when not a hex glyph)
//   is_blank : all segments off
//   is_valid : pattern is one of the 16 hex glyphs
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       nibble,
  output logic             is_blank,
  output logic             is_valid
);
  always_comb begin
    nibble   = 4'h0;
    is_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG7_HEX[i]) begin
        nibble   = 4'(i);
        is_valid = 1'b1;
      end
    end
    is_blank = (pattern == SEG7_BLANK);
  end
endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a 4-digit multiplexed seven-segment scan.
// Waits for {digit_select, seg} to hold SETTLE_CYCLES samples, decodes the
// lit digit, and publishes a frame once all four digits have been seen.
//   clock, reset : rising-edge clock, async active-low reset
//   bus (slave)  : scan lines in, digits/blank_mask/frame_valid/decode_error out
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  seg_scan_decoder_if.slave  bus
);
  localparam logic [7:0] SETTLE_W = 8'(SETTLE_CYCLES);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [DIGITS-1:0]       sel_q, sel_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic [DIGITS-1:0]       seen_q, seen_d;
  logic [DIGITS-1:0]       blank_sh_q, blank_sh_d;
  logic [DIGITS-1:0][3:0]  shadow_q, shadow_d;
  logic [4*DIGITS-1:0]     digits_q, digits_d;
  logic [DIGITS-1:0]       blank_mask_q, blank_mask_d;
  logic                    fv_q, fv_d;
  logic                    err_q, err_d;

  logic                    chg;
  logic                    capture;
  logic [SEG_W-1:0]        seg_ah;
  logic [3:0]              hex_nib;
  logic                    hex_blank, hex_valid;
  logic                    one_hot;
  logic [1:0]              idx;

  // The incoming pair is the "current sample"; the registered pair is the
  // previous one. Capturing on the incoming value gives the t+SETTLE-1 latency.
  assign chg    = {bus.digit_select, bus.seg} != {sel_q, seg_q};
  assign seg_ah = ~bus.seg;

  seg7_to_hex u_dec (
    .pattern  (seg_ah),
    .nibble   (hex_nib),
    .is_blank (hex_blank),
    .is_valid (hex_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= SETTLE;
      cnt_q        <= '0;
      sel_q        <= SEL_IDLE;
      seg_q        <= 7'h7F;
      seen_q       <= '0;
      blank_sh_q   <= '0;
      shadow_q     <= '0;
      digits_q     <= '0;
      blank_mask_q <= '0;
      fv_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      seen_q       <= seen_d;
      blank_sh_q   <= blank_sh_d;
      shadow_q     <= shadow_d;
      digits_q     <= digits_d;
      blank_mask_q <= blank_mask_d;
      fv_q         <= fv_d;
      err_q        <= err_d;
    end
  end

  // Settle tracker: next state, counter and capture strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      SETTLE: begin
        if (chg) begin
          cnt_d = 8'd1;
        end else if (cnt_q + 8'd1 == SETTLE_W) begin
          cnt_d   = SETTLE_W;
          capture = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HELD: begin
        // Held pattern is captured once; only a change re-arms the tracker.
        if (chg) begin
          cnt_d   = 8'd1;
          state_d = SETTLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SETTLE;
      end
    endcase
  end

  // Capture classification and frame assembly.
  always_comb begin
    sel_d        = bus.digit_select;
    seg_d        = bus.seg;
    seen_d       = seen_q;
    blank_sh_d   = blank_sh_q;
    shadow_d     = shadow_q;
    digits_d     = digits_q;
    blank_mask_d = blank_mask_q;
    fv_d         = 1'b0;
    err_d        = 1'b0;

    one_hot = ($countones(~bus.digit_select) == 1);
    idx     = 2'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bus.digit_select[i]) idx = 2'(i);
    end

    if (capture && bus.digit_select != SEL_IDLE) begin
      if (!one_hot || !(hex_valid || hex_blank)) begin
        err_d = 1'b1;
      end else begin
        shadow_d[idx]   = hex_valid ? hex_nib : 4'h0;
        blank_sh_d[idx] = hex_blank;
        seen_d[idx]     = 1'b1;
        // Publish including this capture, and restart collection.
        if (seen_d == '1) begin
          digits_d     = shadow_d;
          blank_mask_d = blank_sh_d;
          fv_d         = 1'b1;
          seen_d       = '0;
        end
      end
    end
  end

  assign bus.digits       = digits_q;
  assign bus.blank_mask   = blank_mask_q;
  assign bus.frame_valid  = fv_q;
  assign bus.decode_error = err_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;
  localparam int S = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  seg_scan_decoder_if bus();
  seg_scan_decoder #(.SETTLE_CYCLES(S)) dut (.clock(clock), .reset(reset), .bus(bus));

  // Active-high glyphs for 0..F.
  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_chk = 0, n_fail = 0, n_fv = 0, n_de = 0;

  // Reference model state
  bit          m_first;
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_seen, m_blank, m_bmask;
  int          m_val [4];
  logic [15:0] m_digits;
  bit          m_fv, m_de;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int n);
    return ~hex_tbl[n];
  endfunction

  function automatic void model_reset();
    m_first = 1; m_prev = '1; m_run = 0;
    m_seen = 0; m_blank = 0; m_bmask = 0; m_digits = 0;
    m_fv = 0; m_de = 0;
    for (int i = 0; i < 4; i++) m_val[i] = 0;
  endfunction

  function automatic void model_capture(input logic [3:0] ds, input logic [6:0] sg);
    logic [6:0] pat;
    int code, d;
    pat = ~sg;
    if (ds == 4'hF) return;
    if ($countones(~ds) != 1) begin m_de = 1; return; end
    d = 0;
    for (int i = 0; i < 4; i++) if (ds[i] == 1'b0) d = i;
    code = -1;
    for (int n = 0; n < 16; n++) if (hex_tbl[n] == pat) code = n;
    if (code >= 0) begin
      m_val[d] = code; m_blank[d] = 0;
    end else if (pat == 7'h00) begin
      m_val[d] = 0; m_blank[d] = 1;
    end else begin
      m_de = 1; return;
    end
    m_seen[d] = 1;
    if (m_seen == 4'hF) begin
      m_digits = 16'(m_val[3]*4096 + m_val[2]*256 + m_val[1]*16 + m_val[0]);
      m_bmask  = m_blank;
      m_fv     = 1;
      m_seen   = 0;
    end
  endfunction

  // A pair is captured on the sample where it has been seen S times in a row.
  function automatic void model_step(input logic [3:0] ds, input logic [6:0] sg);
    m_fv = 0; m_de = 0;
    if (m_first || {ds, sg} != m_prev) m_run = 1;
    else m_run++;
    m_first = 0;
    m_prev  = {ds, sg};
    if (m_run == S) model_capture(ds, sg);
  endfunction

  task automatic tick(input logic [3:0] ds, input logic [6:0] sg);
    bus.digit_select = ds;
    bus.seg          = sg;
    @(posedge clock);
    model_step(ds, sg);
    #1;
    chk("digits", bus.digits, m_digits);
    chk("blank_mask", bus.blank_mask, m_bmask);
    chk("frame_valid", bus.frame_valid, m_fv);
    chk("decode_error", bus.decode_error, m_de);
    if (bus.frame_valid) n_fv++;
    if (bus.decode_error) n_de++;
  endtask

  task automatic slot(input logic [3:0] ds, input logic [6:0] sg, input int n);
    repeat (n) tick(ds, sg);
  endtask

  task automatic do_reset(input int cycles);
    bus.digit_select = 4'hF;
    bus.seg          = 7'h7F;
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_digits", bus.digits, 16'h0);
    chk("rst_blank", bus.blank_mask, 4'h0);
    chk("rst_fv", bus.frame_valid, 0);
    chk("rst_de", bus.decode_error, 0);
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] one, sel;
    logic [6:0] sg;
    int v;
    one = 4'b0001;
    do_reset(3);

    // Idle lines
    n_fv = 0; n_de = 0;
    slot(4'hF, 7'h7F, 50);
    chk("idle_fv_cnt", n_fv, 0);
    chk("idle_de_cnt", n_de, 0);
    chk("idle_digits", bus.digits, 16'h0);

    // Plain scan 3210, with latency check on the last slot
    n_fv = 0;
    slot(4'b1110, seg_of(0), 10);
    slot(4'b1101, seg_of(1), 10);
    slot(4'b1011, seg_of(2), 10);
    slot(4'b0111, seg_of(3), 3);
    chk("lat_early", n_fv, 0);
    tick(4'b0111, seg_of(3));
    chk("lat_fv", bus.frame_valid, 1);
    slot(4'b0111, seg_of(3), 6);
    chk("scan_digits", bus.digits, 16'h3210);
    chk("scan_blank", bus.blank_mask, 4'b0000);
    chk("scan_fv_cnt", n_fv, 1);

    // Blank MSD and F in digit0
    slot(4'b1110, seg_of(15), 10);
    slot(4'b1101, seg_of(1), 10);
    slot(4'b1011, seg_of(2), 10);
    slot(4'b0111, 7'h7F, 10);
    chk("blank_digits", bus.digits, 16'h021F);
    chk("blank_mask", bus.blank_mask, 4'b1000);

    // Short glitch of 8 before a stable 5
    n_de = 0;
    slot(4'b1110, seg_of(0), 10);
    slot(4'b1101, seg_of(1), 10);
    slot(4'b1011, seg_of(8), 2);
    slot(4'b1011, seg_of(5), 10);
    slot(4'b0111, seg_of(3), 10);
    chk("glitch_digits", bus.digits, 16'h3510);
    chk("glitch_de_cnt", n_de, 0);

    // Illegal select, then unknown pattern on a valid slot
    n_de = 0; n_fv = 0;
    slot(4'b1100, seg_of(0), 10);
    slot(4'b1110, 7'b1111110, 10);
    slot(4'b1101, seg_of(1), 10);
    slot(4'b1011, seg_of(2), 10);
    slot(4'b0111, seg_of(3), 10);
    chk("err_de_cnt", n_de, 2);
    chk("err_no_frame", n_fv, 0);
    slot(4'b1110, seg_of(4), 10);
    chk("err_fv_cnt", n_fv, 1);
    chk("err_digits", bus.digits, 16'h3214);

    // Reset in the middle of a frame
    slot(4'b1110, seg_of(1), 10);
    slot(4'b1101, seg_of(2), 10);
    do_reset(2);
    n_fv = 0;
    slot(4'b1110, seg_of(6), 10);
    slot(4'b1101, seg_of(7), 10);
    slot(4'b1011, seg_of(8), 10);
    chk("mid_no_frame", n_fv, 0);
    chk("mid_digits0", bus.digits, 16'h0);
    slot(4'b0111, seg_of(9), 10);
    chk("mid_fv_cnt", n_fv, 1);
    chk("mid_digits", bus.digits, 16'h9876);

    // Randomized scans with glitches, bad selects and bad patterns
    repeat (40) begin
      for (int d = 0; d < 4; d++) begin
        if ($urandom_range(0, 9) == 0) sel = 4'($urandom);
        else sel = ~(one << d);
        v = int'($urandom_range(0, 19));
        if (v < 16)      sg = seg_of(v);
        else if (v < 18) sg = 7'h7F;
        else             sg = 7'($urandom);
        if ($urandom_range(0, 3) == 0)
          slot(4'($urandom), 7'($urandom), int'($urandom_range(1, S - 1)));
        slot(sel, sg, int'($urandom_range(2, 10)));
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
